// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types for the dcache request arbiter: the held request record,
// the arbiter state encoding and the dcache command codes.
package dcache_req_arbiter_pkg;

    localparam logic [4:0] M_XRD    = 5'b00000;
    localparam logic [4:0] M_XWR    = 5'b00001;
    localparam logic [4:0] M_XLR    = 5'b00110;
    localparam logic [4:0] M_XSC    = 5'b00111;
    localparam logic [4:0] M_XA_ADD = 5'b01000;

    typedef struct packed {
        logic [4:0]  cmd;
        logic [39:0] addr;
        logic [3:0]  op_type;
        logic [63:0] data;
        logic [7:0]  tag;
    } dmem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dcache_req_arbiter_if.sv
// Dcache request/response port; master is the arbiter, slave is the dcache.
interface dcache_req_arbiter_if;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [4:0]  dmem_req_cmd_o;
    logic [39:0] dmem_req_addr_o;
    logic [3:0]  dmem_op_type_o;
    logic [63:0] dmem_req_data_o;
    logic [7:0]  dmem_req_tag_o;
    logic        dmem_req_kill_o;
    logic        dmem_resp_valid_i;
    logic        dmem_resp_nack_i;
    logic [7:0]  dmem_resp_tag_i;
    logic [63:0] dmem_resp_data_i;

    modport master (
        output dmem_req_valid_o, dmem_req_cmd_o, dmem_req_addr_o, dmem_op_type_o,
               dmem_req_data_o, dmem_req_tag_o, dmem_req_kill_o,
        input  dmem_req_ready_i, dmem_resp_valid_i, dmem_resp_nack_i,
               dmem_resp_tag_i, dmem_resp_data_i
    );

    modport slave (
        input  dmem_req_valid_o, dmem_req_cmd_o, dmem_req_addr_o, dmem_op_type_o,
               dmem_req_data_o, dmem_req_tag_o, dmem_req_kill_o,
        output dmem_req_ready_i, dmem_resp_valid_i, dmem_resp_nack_i,
               dmem_resp_tag_i, dmem_resp_data_i
    );
endinterface

// File: rtl/dcache_req_arbiter_rr.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ptr_i.
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] grant_oh_o
);
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_oh_o[gi] = req_i[gi] & (~req_i[1-gi] | (ptr_i == 1'(gi)));
        end
    endgenerate
endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares one dcache port between two requesters: round-robin grant, one request
// in flight, replay on nack, tag-bit-0 response routing and post-kill draining.
module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter int MAX_RETRY    = 4,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [1:0][4:0]   req_cmd_i,
    input  logic [1:0][39:0]  req_addr_i,
    input  logic [1:0][3:0]   req_op_type_i,
    input  logic [1:0][63:0]  req_data_i,
    input  logic [1:0][7:0]   req_tag_i,
    input  logic [1:0]        kill_i,
    output logic [1:0]        resp_valid_o,
    output logic [1:0]        resp_err_o,
    output logic [63:0]       resp_data_o,
    dcache_req_arbiter_if.master dmem
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    arb_state_e          state_reg, state_next;
    logic                owner_reg, owner_next;
    logic                rr_ptr_reg, rr_ptr_next;
    logic [RETRY_W-1:0]  retry_cnt_reg, retry_cnt_next;
    logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
    dmem_req_t           held_reg, held_next;

    logic [1:0] cand;
    logic [1:0] grant_oh;
    logic       grant_idx;
    logic       owner_kill;
    logic       resp_match;

    // A killed requester cannot win arbitration, even if it is not the owner.
    assign cand = req_valid_i & ~kill_i;

    rr_arbiter_2 u_rr (
        .req_i      (cand),
        .ptr_i      (rr_ptr_reg),
        .grant_oh_o (grant_oh)
    );

    assign grant_idx  = grant_oh[1];
    assign owner_kill = kill_i[owner_reg];
    assign resp_match = dmem.dmem_resp_valid_i && (dmem.dmem_resp_tag_i[0] == owner_reg);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= 1'b0;
            rr_ptr_reg    <= 1'b0;
            retry_cnt_reg <= '0;
            drain_cnt_reg <= '0;
            held_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            retry_cnt_reg <= retry_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            held_reg      <= held_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        owner_next           = owner_reg;
        rr_ptr_next          = rr_ptr_reg;
        retry_cnt_next       = retry_cnt_reg;
        drain_cnt_next       = drain_cnt_reg;
        held_next            = held_reg;
        req_ready_o          = 2'b00;
        resp_valid_o         = 2'b00;
        resp_err_o           = 2'b00;
        resp_data_o          = '0;
        dmem.dmem_req_kill_o = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (|grant_oh) begin
                    req_ready_o    = grant_oh;
                    // The owner id replaces tag bit 0 so the response can be routed back.
                    held_next      = '{cmd:     req_cmd_i[grant_idx],
                                       addr:    req_addr_i[grant_idx],
                                       op_type: req_op_type_i[grant_idx],
                                       data:    req_data_i[grant_idx],
                                       tag:     {req_tag_i[grant_idx][7:1], grant_idx}};
                    owner_next     = grant_idx;
                    retry_cnt_next = '0;
                    state_next     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Nothing accepted yet, so a kill here needs no dcache kill.
                if (owner_kill) begin
                    state_next = ST_IDLE;
                end else if (dmem.dmem_req_ready_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (owner_kill) begin
                    dmem.dmem_req_kill_o = 1'b1;
                    drain_cnt_next       = '0;
                    state_next           = ST_DRAIN;
                end else if (resp_match) begin
                    resp_valid_o[owner_reg] = 1'b1;
                    resp_data_o             = dmem.dmem_resp_data_i;
                    rr_ptr_next             = ~owner_reg;
                    state_next              = ST_IDLE;
                end else if (dmem.dmem_resp_nack_i) begin
                    if (retry_cnt_reg == RETRY_W'(MAX_RETRY - 1)) begin
                        resp_err_o[owner_reg] = 1'b1;
                        rr_ptr_next           = ~owner_reg;
                        state_next            = ST_IDLE;
                    end else begin
                        retry_cnt_next = retry_cnt_reg + 1'b1;
                        state_next     = ST_ISSUE;
                    end
                end
            end
            ST_DRAIN: begin
                if (dmem.dmem_resp_valid_i || dmem.dmem_resp_nack_i) begin
                    state_next = ST_IDLE;
                end else if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign dmem.dmem_req_valid_o = (state_reg == ST_ISSUE);
    assign dmem.dmem_req_cmd_o   = held_reg.cmd;
    assign dmem.dmem_req_addr_o  = held_reg.addr;
    assign dmem.dmem_op_type_o   = held_reg.op_type;
    assign dmem.dmem_req_data_o  = held_reg.data;
    assign dmem.dmem_req_tag_o   = held_reg.tag;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbitration rules.
module tb_dcache_req_arbiter;
    import dcache_req_arbiter_pkg::*;

    localparam int MAX_RETRY    = 4;
    localparam int DRAIN_CYCLES = 16;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][4:0]  req_cmd_i;
    logic [1:0][39:0] req_addr_i;
    logic [1:0][3:0]  req_op_type_i;
    logic [1:0][63:0] req_data_i;
    logic [1:0][7:0]  req_tag_i;
    logic [1:0]       kill_i;
    logic [1:0]       resp_valid_o;
    logic [1:0]       resp_err_o;
    logic [63:0]      resp_data_o;

    dcache_req_arbiter_if dmem_bus ();

    dcache_req_arbiter #(.MAX_RETRY(MAX_RETRY), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_cmd_i     (req_cmd_i),
        .req_addr_i    (req_addr_i),
        .req_op_type_i (req_op_type_i),
        .req_data_i    (req_data_i),
        .req_tag_i     (req_tag_i),
        .kill_i        (kill_i),
        .resp_valid_o  (resp_valid_o),
        .resp_err_o    (resp_err_o),
        .resp_data_o   (resp_data_o),
        .dmem          (dmem_bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int model_rr = 0;   // requester that wins the next tie

    logic [120:0] dut_bus;
    logic [120:0] exp_bus;
    logic [255:0] all_out;
    assign dut_bus = {dmem_bus.dmem_req_cmd_o, dmem_bus.dmem_req_addr_o, dmem_bus.dmem_op_type_o,
                      dmem_bus.dmem_req_data_o, dmem_bus.dmem_req_tag_o};
    assign all_out = 256'({req_ready_o, resp_valid_o, resp_err_o, resp_data_o,
                           dmem_bus.dmem_req_valid_o, dmem_bus.dmem_req_kill_o, dut_bus});

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_inputs();
        req_valid_i = 2'b00;
        kill_i      = 2'b00;
        dmem_bus.dmem_req_ready_i  = 1'b0;
        dmem_bus.dmem_resp_valid_i = 1'b0;
        dmem_bus.dmem_resp_nack_i  = 1'b0;
        dmem_bus.dmem_resp_tag_i   = 8'h00;
        dmem_bus.dmem_resp_data_i  = 64'h0;
    endtask

    task automatic set_req(input int g, input logic [4:0] cmd, input logic [39:0] addr,
                           input logic [3:0] op, input logic [63:0] data, input logic [7:0] tag);
        req_cmd_i[g] = cmd; req_addr_i[g] = addr; req_op_type_i[g] = op;
        req_data_i[g] = data; req_tag_i[g] = tag;
    endtask

    task automatic rand_req(input int g);
        set_req(g, 5'($urandom_range(0, 8)), {8'($urandom), 32'($urandom)}, 4'($urandom),
                {32'($urandom), 32'($urandom)}, 8'($urandom));
    endtask

    // The request the dcache must see for owner g: requester fields, tag bit 0 = owner.
    task automatic capture_exp(input int g);
        exp_bus = {req_cmd_i[g], req_addr_i[g], req_op_type_i[g], req_data_i[g],
                   req_tag_i[g][7:1], 1'(g)};
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        idle_inputs();
        rand_req(0); rand_req(1);
        tick(); tick(); tick();
        #1;
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %0h expected 0", all_out);
        else n_pass++;
        rstn_i = 1'b1;
        model_rr = 0;
        tick();
    endtask

    task automatic test_rr_both();
        logic [39:0] a0, a1;
        a0 = 40'h00_1000_0040; a1 = 40'h00_2000_0080;
        set_req(0, M_XRD, a0, 4'h3, 64'h0, 8'h22);
        set_req(1, M_XWR, a1, 4'h3, 64'h1111_2222_3333_4444, 8'h56);
        req_valid_i = 2'b11;
        #1;
        n_checks++;
        if (req_ready_o !== 2'(1 << model_rr)) $display("FAIL rr_first_grant: got %b expected %b", req_ready_o, 2'(1 << model_rr));
        else n_pass++;
        tick();
        req_valid_i = 2'b10;
        dmem_bus.dmem_req_ready_i = 1'b1;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_addr_o !== a0 || dmem_bus.dmem_req_tag_o !== 8'h22 || dmem_bus.dmem_req_valid_o !== 1'b1)
            $display("FAIL rr_req0_issue: got addr %0h tag %0h expected addr %0h tag 22", dmem_bus.dmem_req_addr_o, dmem_bus.dmem_req_tag_o, a0);
        else n_pass++;
        tick();
        dmem_bus.dmem_req_ready_i  = 1'b0;
        dmem_bus.dmem_resp_valid_i = 1'b1;
        dmem_bus.dmem_resp_tag_i   = 8'h22;
        dmem_bus.dmem_resp_data_i  = 64'hAAAA;
        #1;
        n_checks++;
        if (resp_valid_o !== 2'b01 || resp_data_o !== 64'hAAAA) $display("FAIL rr_resp0: got %b/%0h expected 01/aaaa", resp_valid_o, resp_data_o);
        else n_pass++;
        model_rr = 1;
        tick();
        dmem_bus.dmem_resp_valid_i = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 2'b10) $display("FAIL rr_second_grant: got %b expected 10", req_ready_o);
        else n_pass++;
        tick();
        req_valid_i = 2'b00;
        dmem_bus.dmem_req_ready_i = 1'b1;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_tag_o !== 8'h57 || dmem_bus.dmem_req_addr_o !== a1)
            $display("FAIL rr_req1_issue: got tag %0h addr %0h expected 57 %0h", dmem_bus.dmem_req_tag_o, dmem_bus.dmem_req_addr_o, a1);
        else n_pass++;
        tick();
        dmem_bus.dmem_req_ready_i  = 1'b0;
        dmem_bus.dmem_resp_valid_i = 1'b1;
        dmem_bus.dmem_resp_tag_i   = 8'h57;
        dmem_bus.dmem_resp_data_i  = 64'hBBBB;
        #1;
        n_checks++;
        if (resp_valid_o !== 2'b10 || resp_data_o !== 64'hBBBB) $display("FAIL rr_resp1: got %b/%0h expected 10/bbbb", resp_valid_o, resp_data_o);
        else n_pass++;
        model_rr = 0;
        tick();
        idle_inputs();
        $display("txn rr_both: req0 then req1 served");
    endtask

    task automatic test_single_load();
        set_req(0, M_XRD, 40'h00_8000_1000, 4'h3, 64'h0, 8'h14);
        req_valid_i = 2'b01;
        dmem_bus.dmem_req_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 2'b01) $display("FAIL load_grant: got %b expected 01", req_ready_o);
        else n_pass++;
        tick();
        req_valid_i = 2'b00;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_valid_o !== 1'b1 || dmem_bus.dmem_req_tag_o !== 8'h14 || dmem_bus.dmem_req_addr_o !== 40'h00_8000_1000)
            $display("FAIL load_issue: got v%b tag %0h addr %0h expected v1 tag 14 addr 80001000", dmem_bus.dmem_req_valid_o, dmem_bus.dmem_req_tag_o, dmem_bus.dmem_req_addr_o);
        else n_pass++;
        tick();
        dmem_bus.dmem_req_ready_i  = 1'b0;
        dmem_bus.dmem_resp_valid_i = 1'b1;
        dmem_bus.dmem_resp_tag_i   = 8'h14;
        dmem_bus.dmem_resp_data_i  = 64'hDEADBEEF;
        #1;
        n_checks++;
        if (resp_valid_o !== 2'b01 || resp_data_o !== 64'hDEADBEEF) $display("FAIL load_resp: got %b/%0h expected 01/deadbeef", resp_valid_o, resp_data_o);
        else n_pass++;
        model_rr = 1;
        tick();
        dmem_bus.dmem_resp_valid_i = 1'b0;
        #1;
        n_checks++;
        if (resp_valid_o !== 2'b00 || resp_data_o !== 64'h0) $display("FAIL load_resp_idle: got %b/%0h expected 00/0", resp_valid_o, resp_data_o);
        else n_pass++;
        $display("txn single_load: addr 80001000 tag 14 data deadbeef");
    endtask

    // n_nacks nacks on a req1 request; an answer follows unless the retry limit is hit.
    task automatic test_nack_retry(input int n_nacks);
        int  issues;
        bit  errored;
        issues  = 0;
        errored = 0;
        set_req(1, M_XWR, 40'h00_4000_0100, 4'h3, 64'hCAFE_F00D_1234_5678, 8'h30);
        capture_exp(1);
        req_valid_i = 2'b10;
        tick();
        req_valid_i = 2'b00;
        rand_req(1);
        for (int i = 0; i <= n_nacks && !errored; i++) begin
            dmem_bus.dmem_req_ready_i = 1'b1;
            #1;
            if (dmem_bus.dmem_req_valid_o === 1'b1 && dut_bus === exp_bus) issues++;
            tick();
            dmem_bus.dmem_req_ready_i = 1'b0;
            if (i < n_nacks) begin
                dmem_bus.dmem_resp_nack_i = 1'b1;
                #1;
                if (i == MAX_RETRY - 1) begin
                    n_checks++;
                    if (resp_err_o !== 2'b10 || resp_valid_o !== 2'b00) $display("FAIL retry_error: got err %b valid %b expected 10/00", resp_err_o, resp_valid_o);
                    else n_pass++;
                    errored  = 1;
                    model_rr = 0;
                end
                tick();
                dmem_bus.dmem_resp_nack_i = 1'b0;
            end else begin
                dmem_bus.dmem_resp_valid_i = 1'b1;
                dmem_bus.dmem_resp_tag_i   = 8'h31;
                dmem_bus.dmem_resp_data_i  = 64'h77;
                #1;
                n_checks++;
                if (resp_valid_o !== 2'b10 || resp_err_o !== 2'b00) $display("FAIL retry_resp: got valid %b err %b expected 10/00", resp_valid_o, resp_err_o);
                else n_pass++;
                model_rr = 0;
                tick();
                dmem_bus.dmem_resp_valid_i = 1'b0;
            end
        end
        n_checks++;
        if (issues !== (errored ? MAX_RETRY : n_nacks + 1)) $display("FAIL retry_issue_count: got %0d expected %0d", issues, errored ? MAX_RETRY : n_nacks + 1);
        else n_pass++;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_valid_o !== 1'b0) $display("FAIL retry_back_idle: got %b expected 0", dmem_bus.dmem_req_valid_o);
        else n_pass++;
        $display("txn nack_retry: nacks %0d issues %0d error %0d", n_nacks, issues, errored);
    endtask

    task automatic test_kill_paths();
        int cycles;
        // Kill in WAIT, late response 3 cycles later is swallowed.
        set_req(0, M_XRD, 40'h00_0000_2000, 4'h2, 64'h0, 8'h40);
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        dmem_bus.dmem_req_ready_i = 1'b1;
        tick();
        dmem_bus.dmem_req_ready_i = 1'b0;
        kill_i = 2'b01;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_kill_o !== 1'b1) $display("FAIL kill_wait_pulse: got %b expected 1", dmem_bus.dmem_req_kill_o);
        else n_pass++;
        tick();
        kill_i = 2'b00;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_kill_o !== 1'b0) $display("FAIL kill_pulse_width: got %b expected 0", dmem_bus.dmem_req_kill_o);
        else n_pass++;
        tick(); tick();
        dmem_bus.dmem_resp_valid_i = 1'b1;
        dmem_bus.dmem_resp_tag_i   = 8'h40;
        dmem_bus.dmem_resp_data_i  = 64'h55;
        #1;
        n_checks++;
        if (resp_valid_o !== 2'b00 || resp_data_o !== 64'h0) $display("FAIL drain_swallow: got %b/%0h expected 00/0", resp_valid_o, resp_data_o);
        else n_pass++;
        tick();
        dmem_bus.dmem_resp_valid_i = 1'b0;
        set_req(1, M_XRD, 40'h00_0000_3000, 4'h2, 64'h0, 8'h12);
        req_valid_i = 2'b10;
        #1;
        n_checks++;
        if (req_ready_o !== 2'b10) $display("FAIL drain_to_idle: got %b expected 10", req_ready_o);
        else n_pass++;
        // Kill in ISSUE with ready the same cycle: no kill, no WAIT.
        tick();
        req_valid_i = 2'b00;
        kill_i = 2'b10;
        dmem_bus.dmem_req_ready_i = 1'b1;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_kill_o !== 1'b0) $display("FAIL kill_issue_nokill: got %b expected 0", dmem_bus.dmem_req_kill_o);
        else n_pass++;
        tick();
        kill_i = 2'b00;
        dmem_bus.dmem_req_ready_i = 1'b0;
        set_req(0, M_XRD, 40'h00_0000_4000, 4'h2, 64'h0, 8'h08);
        req_valid_i = 2'b01;
        #1;
        n_checks++;
        if (req_ready_o !== 2'b01 || dmem_bus.dmem_req_valid_o !== 1'b0) $display("FAIL kill_issue_idle: got ready %b valid %b expected 01/0", req_ready_o, dmem_bus.dmem_req_valid_o);
        else n_pass++;
        // Kill in WAIT with no late answer: drain times out.
        tick();
        req_valid_i = 2'b00;
        dmem_bus.dmem_req_ready_i = 1'b1;
        tick();
        dmem_bus.dmem_req_ready_i = 1'b0;
        kill_i = 2'b01;
        tick();
        kill_i = 2'b00;
        req_valid_i = 2'b10;
        cycles = 0;
        #1;
        while (req_ready_o !== 2'b10 && cycles < 40) begin
            tick();
            cycles++;
            #1;
        end
        n_checks++;
        if (cycles !== DRAIN_CYCLES) $display("FAIL drain_timeout: got %0d cycles expected %0d", cycles, DRAIN_CYCLES);
        else n_pass++;
        // Leave the new grant pending, then abandon it with a kill in ISSUE.
        tick();
        req_valid_i = 2'b00;
        kill_i = 2'b10;
        tick();
        idle_inputs();
        $display("txn kill_paths: drain timeout after %0d cycles", cycles);
    endtask

    task automatic test_reset_mid();
        set_req(0, M_XWR, 40'h00_0BAD_0000, 4'h3, 64'h99, 8'h66);
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        dmem_bus.dmem_req_ready_i = 1'b1;
        tick();
        dmem_bus.dmem_req_ready_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_mid_outputs: got %0h expected 0", all_out);
        else n_pass++;
        tick();
        rstn_i = 1'b1;
        model_rr = 0;
        tick();
        set_req(1, M_XRD, 40'h00_0600_0000, 4'h3, 64'h0, 8'hA0);
        req_valid_i = 2'b10;
        #1;
        n_checks++;
        if (req_ready_o !== 2'b10) $display("FAIL reset_mid_regrant: got %b expected 10", req_ready_o);
        else n_pass++;
        tick();
        req_valid_i = 2'b00;
        dmem_bus.dmem_req_ready_i = 1'b1;
        #1;
        n_checks++;
        if (dmem_bus.dmem_req_tag_o !== 8'hA1 || dmem_bus.dmem_req_kill_o !== 1'b0) $display("FAIL reset_mid_issue: got tag %0h kill %b expected a1/0", dmem_bus.dmem_req_tag_o, dmem_bus.dmem_req_kill_o);
        else n_pass++;
        tick();
        dmem_bus.dmem_req_ready_i  = 1'b0;
        dmem_bus.dmem_resp_valid_i = 1'b1;
        dmem_bus.dmem_resp_tag_i   = 8'hA1;
        tick();
        idle_inputs();
        model_rr = 0;
        $display("txn reset_mid: request abandoned, req1 served after release");
    endtask

    task automatic test_random(input int n_txn);
        logic [1:0] rv, kl, cand;
        int g, delay, n_nacks;
        bit errored;
        logic [63:0] rdata;
        for (int t = 0; t < n_txn; t++) begin
            rand_req(0); rand_req(1);
            rv = 2'($urandom_range(1, 3));
            kl = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
            cand = rv & ~kl;
            if (cand == 2'b00) begin kl = 2'b00; cand = rv; end
            g = (cand == 2'b11) ? model_rr : ((cand == 2'b10) ? 1 : 0);
            req_valid_i = rv;
            kill_i = kl;
            #1;
            n_checks++;
            if (req_ready_o !== 2'(1 << g)) $display("FAIL rand_grant: txn %0d got %b expected %b", t, req_ready_o, 2'(1 << g));
            else n_pass++;
            capture_exp(g);
            tick();
            req_valid_i = 2'b00;
            kill_i = 2'b00;
            rand_req(0); rand_req(1);
            delay   = $urandom_range(0, 2);
            n_nacks = $urandom_range(0, 5);
            errored = 0;
            for (int i = 0; i <= n_nacks && !errored; i++) begin
                for (int d = 0; d < delay; d++) tick();
                dmem_bus.dmem_req_ready_i = 1'b1;
                #1;
                n_checks++;
                if (dmem_bus.dmem_req_valid_o !== 1'b1 || dut_bus !== exp_bus)
                    $display("FAIL rand_issue: txn %0d try %0d got v%b %0h expected v1 %0h", t, i, dmem_bus.dmem_req_valid_o, dut_bus, exp_bus);
                else n_pass++;
                tick();
                dmem_bus.dmem_req_ready_i = 1'b0;
                if ($urandom_range(0, 2) == 0) begin
                    dmem_bus.dmem_resp_valid_i = 1'b1;
                    dmem_bus.dmem_resp_tag_i   = {exp_bus[7:1], ~exp_bus[0]};
                    dmem_bus.dmem_resp_data_i  = 64'h1;
                    #1;
                    n_checks++;
                    if (resp_valid_o !== 2'b00) $display("FAIL rand_bad_tag: txn %0d got %b expected 00", t, resp_valid_o);
                    else n_pass++;
                    tick();
                    dmem_bus.dmem_resp_valid_i = 1'b0;
                end
                if (i < n_nacks) begin
                    dmem_bus.dmem_resp_nack_i = 1'b1;
                    #1;
                    if (i == MAX_RETRY - 1) begin
                        errored = 1;
                        n_checks++;
                        if (resp_err_o !== 2'(1 << g) || resp_valid_o !== 2'b00) $display("FAIL rand_err: txn %0d got %b expected %b", t, resp_err_o, 2'(1 << g));
                        else n_pass++;
                    end
                    tick();
                    dmem_bus.dmem_resp_nack_i = 1'b0;
                end else begin
                    rdata = {32'($urandom), 32'($urandom)};
                    dmem_bus.dmem_resp_valid_i = 1'b1;
                    dmem_bus.dmem_resp_tag_i   = exp_bus[7:0];
                    dmem_bus.dmem_resp_data_i  = rdata;
                    #1;
                    n_checks++;
                    if (resp_valid_o !== 2'(1 << g) || resp_data_o !== rdata || resp_err_o !== 2'b00)
                        $display("FAIL rand_resp: txn %0d got %b/%0h expected %b/%0h", t, resp_valid_o, resp_data_o, 2'(1 << g), rdata);
                    else n_pass++;
                    tick();
                    dmem_bus.dmem_resp_valid_i = 1'b0;
                end
            end
            model_rr = 1 - g;
            $display("txn rand %0d: valid %b kill %b owner %0d nacks %0d error %0d", t, rv, kl, g, n_nacks, errored);
        end
    endtask

    initial begin
        test_reset();
        test_rr_both();
        test_single_load();
        test_nack_retry(3);
        test_nack_retry(4);
        test_kill_paths();
        test_reset_mid();
        test_random(40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
